// File: rtl/sram_port0_ctrl.sv
// Port-0 (RW) initiator for a 1rw1r OpenRAM macro: request stream -> macro pins,
// macro read data -> in-order response FIFO with valid/ready output.
module sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_WMASKS-1:0] req_be_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  csb0_o,
  output logic                  web0_o,
  output logic [NUM_WMASKS-1:0] wmask0_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0] din0_o,
  input  logic [DATA_WIDTH-1:0] dout0_i
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_L  = (CW + 1)'(RESP_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

  logic [DATA_WIDTH-1:0] fifo_mem_reg [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  rd_pend_reg, rd_pend_next;
  logic [CW:0]           occupancy;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Ready counts the in-flight read as occupied, so the FIFO can never overflow;
  // it deliberately ignores a same-cycle pop to keep resp_ready_i off this path.
  assign occupancy    = {1'b0, count_reg} + {{CW{1'b0}}, rd_pend_reg};
  assign req_ready_o  = rst_ni & (occupancy < DEPTH_L);
  assign accept       = req_valid_i & req_ready_o;
  assign push         = rd_pend_reg;
  assign resp_valid_o = (count_reg != '0);
  assign pop          = resp_valid_o & resp_ready_i;
  assign resp_rdata_o = fifo_mem_reg[rd_ptr_reg];

  assign csb0_o  = ~accept;
  assign web0_o  = ~(rst_ni & req_we_i);
  assign addr0_o = req_addr_i;
  assign din0_o  = req_wdata_i;

  generate
    for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_wmask
      assign wmask0_o[gi] = rst_ni & req_we_i & req_be_i[gi];
    end
  endgenerate

  always_comb begin
    rd_pend_next = accept & ~req_we_i;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_pend_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      rd_pend_reg <= rd_pend_next;
    end
  end

  // Data storage needs no reset: count_reg alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_reg[wr_ptr_reg] <= dout0_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count_reg == FULL_CNT)));

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Directed bench for sram_port0_ctrl with a behavioural 1rw macro model on port 0.
module tb_sram_port0_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [7:0]  req_addr_i;
  logic [3:0]  req_be_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        csb0_o, web0_o;
  logic [3:0]  wmask0_o;
  logic [7:0]  addr0_o;
  logic [31:0] din0_o, dout0_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  sram_port0_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4), .RESP_DEPTH(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .csb0_o(csb0_o), .web0_o(web0_o), .wmask0_o(wmask0_o), .addr0_o(addr0_o),
    .din0_o(din0_o), .dout0_i(dout0_i)
  );

  // Macro model: samples pins at the rising edge, acts at the falling edge.
  function automatic logic [31:0] mem_init(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  logic [31:0] sram [256];
  logic        init_done = 1'b0;
  logic        lat_csb = 1'b1, lat_web = 1'b1;
  logic [7:0]  lat_addr;
  logic [3:0]  lat_mask;
  logic [31:0] lat_din;

  always @(posedge clk_i) begin
    lat_csb  <= csb0_o;
    lat_web  <= web0_o;
    lat_addr <= addr0_o;
    lat_mask <= wmask0_o;
    lat_din  <= din0_o;
  end

  always @(negedge clk_i) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) sram[i] <= mem_init(8'(i));
      init_done <= 1'b1;
    end else if (!lat_csb) begin
      if (!lat_web) begin
        for (int b = 0; b < 4; b++) begin
          if (lat_mask[b]) sram[lat_addr][8*b +: 8] <= lat_din[8*b +: 8];
        end
      end else begin
        dout0_i <= sram[lat_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input string tag);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = a; req_be_i = be; req_wdata_i = d;
    #1;
    check({tag, "_rdy"},  32'(req_ready_o), 32'd1);
    check({tag, "_csb"},  32'(csb0_o),      32'd0);
    check({tag, "_web"},  32'(web0_o),      32'd0);
    check({tag, "_wmsk"}, 32'(wmask0_o),    32'(be));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_we_i = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = a; resp_ready_i = 1'b1;
    #1;
    check({tag, "_csb"},  32'(csb0_o),  32'd0);
    check({tag, "_addr"}, 32'(addr0_o), 32'(a));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check({tag, "_v0"}, 32'(resp_valid_o), 32'd0);
    @(posedge clk_i); #1;
    check({tag, "_v1"},   32'(resp_valid_o), 32'd1);
    check({tag, "_data"}, resp_rdata_o,      exp);
    @(posedge clk_i); #1;
    check({tag, "_v2"}, 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b1; req_be_i = 4'hF;
    req_addr_i = 8'h00; req_wdata_i = 32'h0; resp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_ready", 32'(req_ready_o),  32'd0);
    check("rst_csb",   32'(csb0_o),       32'd1);
    check("rst_web",   32'(web0_o),       32'd1);
    check("rst_wmask", 32'(wmask0_o),     32'd0);
    rst_ni = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready_o), 32'd1);
    check("idle_csb",       32'(csb0_o),      32'd1);
    @(posedge clk_i); #1;

    // 1: full write then readback
    do_write(8'h10, 32'hDEADBEEF, 4'hF, "t1_wr");
    do_read(8'h10, 32'hDEADBEEF, "t1_rd");

    // 2: partial byte write
    do_write(8'h11, 32'h00000000, 4'hF, "t2_pre");
    do_write(8'h11, 32'hA5A5A5A5, 4'b0101, "t2_wr");
    do_read(8'h11, 32'h00A500A5, "t2_rd");

    // 3: back-to-back reads, responses on consecutive cycles
    resp_ready_i = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      if (t < 8) begin
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 8'(t);
      end else begin
        req_valid_i = 1'b0;
      end
      #1;
      if (t < 8) check($sformatf("t3_rdy%0d", t), 32'(req_ready_o), 32'd1);
      if (t >= 2 && t < 10) begin
        check($sformatf("t3_v%0d", t), 32'(resp_valid_o), 32'd1);
        check($sformatf("t3_d%0d", t), resp_rdata_o, mem_init(8'(t - 2)));
      end else begin
        check($sformatf("t3_v%0d", t), 32'(resp_valid_o), 32'd0);
      end
      @(posedge clk_i); #1;
    end

    // 4: backpressure fills the response path, then drains in order
    resp_ready_i = 1'b0;
    for (int t = 0; t < 3; t++) begin
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 8'(8'h20 + t);
      #1;
      check($sformatf("t4_rdy%0d", t), 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
    end
    req_addr_i = 8'h23;
    #1;
    check("t4_full_rdy", 32'(req_ready_o), 32'd0);
    check("t4_full_csb", 32'(csb0_o),      32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("t4_stall_rdy", 32'(req_ready_o), 32'd0);
    resp_ready_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      check($sformatf("t4_v%0d", t), 32'(resp_valid_o), 32'd1);
      check($sformatf("t4_d%0d", t), resp_rdata_o, mem_init(8'(8'h20 + t)));
      @(posedge clk_i); #1;
    end
    check("t4_empty", 32'(resp_valid_o), 32'd0);
    check("t4_rdy_back", 32'(req_ready_o), 32'd1);

    // 5: zero byte-enable write is a no-op
    do_write(8'h30, 32'h12345678, 4'hF, "t5_pre");
    do_write(8'h30, 32'hFFFFFFFF, 4'h0, "t5_wr");
    do_read(8'h30, 32'h12345678, "t5_rd");

    // 6: reset while a read is pending
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 8'h10; resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("t6_csb",   32'(csb0_o),       32'd1);
    check("t6_rdy",   32'(req_ready_o),  32'd0);
    check("t6_valid", 32'(resp_valid_o), 32'd0);
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("t6_rst_valid", 32'(resp_valid_o), 32'd0);
    rst_ni = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk_i); #1;
      check($sformatf("t6_no_resp%0d", t), 32'(resp_valid_o), 32'd0);
    end
    do_read(8'h10, 32'hDEADBEEF, "t6_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
